multi_button_debouncer: RTL

//  N-channel debouncer for the board push-buttons. All channels share one tick prescaler.

---
 rtl/multi_button_debouncer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button debouncer.
// All channels share one sample-tick prescaler. Each channel has a 2-FF
// synchroniser, a stability counter and an IDLE/HOLD/REPEAT FSM. The FSM
// produces a clean level plus single-cycle press/release/auto-repeat pulses.
// There are no handshakes: every output is a plain registered level or a
// strobe in the Clk domain, with no back-pressure.
module multi_button_debouncer #(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 125000,
   parameter int STABLE_TICKS = 4,
   parameter int ACTIVE_LOW   = 0,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 200,
   parameter int REPEAT_RATE  = 40
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [CHANNELS-1:0]   ButtonIn,
   output logic [CHANNELS-1:0]   ButtonLevel,
   output logic [CHANNELS-1:0]   ButtonPress,
   output logic [CHANNELS-1:0]   ButtonRelease,
   output logic [CHANNELS-1:0]   ButtonRepeat,
   output logic [2*CHANNELS-1:0] StateDbg
);

   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] RATE_LAST = HW'(REPEAT_RATE - 1);

   // Pin value of a released button, loaded into the synchronisers at reset
   localparam logic [CHANNELS-1:0] RELEASED = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_e;

   logic [PW-1:0]       pre_q, pre_d;
   logic                tick;
   logic [CHANNELS-1:0] sync1_q, sync2_q, raw;

   // Shared prescaler: tick strobes on the last count, then the count wraps
   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   // Prescaler register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) pre_q <= '0;
      else       pre_q <= pre_d;
   end

   // Two-stage synchroniser for the asynchronous pins
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= RELEASED;
         sync2_q <= RELEASED;
      end else begin
         sync1_q <= ButtonIn;
         sync2_q <= sync1_q;
      end
   end

   // Polarity-normalised pin value: 1 means pressed
   assign raw = sync2_q ^ RELEASED;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_e        state_q, state_d;
      logic [SW-1:0] stab_q, stab_d;
      logic [HW-1:0] hold_q, hold_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          rep_q, rep_d;
      logic          accept;

      // Stability counter: any agreeing tick discards partial progress
      always_comb begin
         stab_d = stab_q;
         accept = 1'b0;
         if (tick) begin
            if (raw[c] == level_q) begin
               stab_d = '0;
            end else if (stab_q == STAB_LAST) begin
               stab_d = '0;
               accept = 1'b1;
            end else begin
               stab_d = stab_q + SW'(1);
            end
         end
      end

      // Channel FSM: level tracking, press/release, hold timing and repeats
      always_comb begin
         state_d = state_q;
         hold_d  = hold_q;
         level_d = level_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         rep_d   = 1'b0;
         if (tick) begin
            case (state_q)
               ST_IDLE: begin
                  if (accept) begin
                     state_d = ST_HOLD;
                     level_d = 1'b1;
                     press_d = 1'b1;
                     hold_d  = '0;
                  end
               end
               ST_HOLD: begin
                  if (accept) begin
                     state_d = ST_IDLE;
                     level_d = 1'b0;
                     rel_d   = 1'b1;
                     hold_d  = '0;
                  end else if ((REPEAT_EN != 0) && (hold_q == HOLD_LAST)) begin
                     state_d = ST_REPEAT;
                     rep_d   = 1'b1;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end
               ST_REPEAT: begin
                  // A release on the same tick wins over a due repeat
                  if (accept) begin
                     state_d = ST_IDLE;
                     level_d = 1'b0;
                     rel_d   = 1'b1;
                     hold_d  = '0;
                  end else if (hold_q == RATE_LAST) begin
                     rep_d  = 1'b1;
                     hold_d = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  level_d = 1'b0;
                  hold_d  = '0;
               end
            endcase
         end
      end

      // Channel state and registered outputs
      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) begin
            state_q <= ST_IDLE;
            stab_q  <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
         end
      end

      assign ButtonLevel[c]     = level_q;
      assign ButtonPress[c]     = press_q;
      assign ButtonRelease[c]   = rel_q;
      assign ButtonRepeat[c]    = rep_q;
      assign StateDbg[2*c +: 2] = state_q;
   end

endmodule
